// File: rtl/riscv_top_if.sv
// Memory and register-file bus of the riscv_top core.
// The master side is the core, the slave side is the SRAMs plus the register file.
//
// Signalling: there is no valid/ready pairing on this bus.
// - A memory access is requested by pulling its CSN low for one cycle.
// - The SRAM samples the request on the rising edge that ends that cycle.
// - Read data is valid during the following cycle.
// - D_MEM_WEN=0 with D_MEM_CSN=0 writes D_MEM_DOUT to the line at that edge.
// - Register reads are combinational.
// - A register write happens at the edge that ends a cycle with RF_WE=1.
interface riscv_top_if;
  logic         I_MEM_CSN;
  logic [11:0]  I_MEM_ADDR;
  logic [31:0]  I_MEM_DI;
  logic         D_MEM_CSN;
  logic         D_MEM_WEN;
  logic [9:0]   D_MEM_ADDR;
  logic [127:0] D_MEM_DOUT;
  logic [127:0] D_MEM_DI;
  logic [4:0]   RF_RA1;
  logic [4:0]   RF_RA2;
  logic [31:0]  RF_RD1;
  logic [31:0]  RF_RD2;
  logic [4:0]   RF_WA1;
  logic [31:0]  RF_WD;
  logic         RF_WE;

  modport master (
    output I_MEM_CSN, I_MEM_ADDR, D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_DOUT,
           RF_RA1, RF_RA2, RF_WA1, RF_WD, RF_WE,
    input  I_MEM_DI, D_MEM_DI, RF_RD1, RF_RD2
  );

  modport slave (
    input  I_MEM_CSN, I_MEM_ADDR, D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_DOUT,
           RF_RA1, RF_RA2, RF_WA1, RF_WD, RF_WE,
    output I_MEM_DI, D_MEM_DI, RF_RD1, RF_RD2
  );
endinterface

// File: rtl/riscv_top.sv
// Multicycle RV32I-subset core: IF -> ID -> EX (-> MEM) per instruction.
// It has an external register file, a word-wide instruction SRAM and a 128-bit line data SRAM.
// Stores are read-modify-write on a whole line.
// RSTn is a synchronous, active-high reset (1 = reset).
module riscv_top (
  input  logic        CLK,
  input  logic        RSTn,
  riscv_top_if.master bus,
  output logic        HALT,
  output logic [31:0] NUM_INST,
  output logic [31:0] OUTPUT_PORT,
  output logic [2:0]  o_dbg_state
);
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [31:0] INSN_EBREAK = 32'h00100073;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t       r_state;
  logic [11:0]  r_pc;
  logic [31:0]  r_ir;
  logic [13:2]  r_ea;        // word address of the pending load/store
  logic [31:0]  r_rs2;       // store data captured in EX
  logic         r_halt;
  logic [31:0]  r_num_inst;
  logic [31:0]  r_out;

  logic [6:0]   w_opc;
  logic [2:0]   w_f3;
  logic [6:0]   w_f7;
  logic [4:0]   w_rd;
  logic         w_is_lw;
  logic         w_is_sw;
  logic         w_is_mem;
  logic         w_is_ebreak;
  logic         w_is_alu;
  logic [31:0]  w_imm;
  logic [31:0]  w_op_b;
  logic [4:0]   w_shamt;
  logic [31:0]  w_alu;
  logic [13:2]  w_ea;
  logic [31:0]  w_lane;
  logic [127:0] w_line;
  logic         w_active;
  logic         w_we_ex;
  logic         w_we_mem;

  assign w_opc       = r_ir[6:0];
  assign w_f3        = r_ir[14:12];
  assign w_f7        = r_ir[31:25];
  assign w_rd        = r_ir[11:7];
  assign w_is_lw     = (w_opc == OPC_LOAD)  && (w_f3 == 3'b010);
  assign w_is_sw     = (w_opc == OPC_STORE) && (w_f3 == 3'b010);
  assign w_is_mem    = w_is_lw || w_is_sw;
  assign w_is_ebreak = (r_ir == INSN_EBREAK);

  // Store immediates are split across the word; everything else uses the I layout.
  assign w_imm = w_is_sw ? {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]}
                         : {{20{r_ir[31]}}, r_ir[31:20]};

  // Only the line index and lane select matter, so the adder is cut down to 14 bits.
  assign w_ea = 12'((bus.RF_RD1[13:0] + w_imm[13:0]) >> 2);

  // Lane k of a line occupies bits [32k+31:32k].
  assign w_lane = bus.D_MEM_DI[{r_ea[3:2], 5'b00000} +: 32];

  // Decide whether IR is a supported ALU/LUI encoding; anything else retires as a NOP.
  always_comb begin
    w_is_alu = 1'b0;
    case (w_opc)
      OPC_OPIMM: begin
        case (w_f3)
          3'b001:  w_is_alu = (w_f7 == 7'b0000000);
          3'b101:  w_is_alu = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          default: w_is_alu = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_is_alu = (w_f7 == 7'b0000000) ||
                   ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OPC_LUI: w_is_alu = 1'b1;
      default: w_is_alu = 1'b0;
    endcase
  end

  // ALU: operand B is rs2 for register ops and the immediate otherwise.
  always_comb begin
    w_op_b  = (w_opc == OPC_OP) ? bus.RF_RD2 : w_imm;
    w_shamt = w_op_b[4:0];
    w_alu   = 32'd0;
    case (w_f3)
      3'b000:  w_alu = ((w_opc == OPC_OP) && w_f7[5]) ? (bus.RF_RD1 - w_op_b)
                                                      : (bus.RF_RD1 + w_op_b);
      3'b001:  w_alu = bus.RF_RD1 << w_shamt;
      3'b010:  w_alu = {31'd0, ($signed(bus.RF_RD1) < $signed(w_op_b))};
      3'b011:  w_alu = {31'd0, (bus.RF_RD1 < w_op_b)};
      3'b100:  w_alu = bus.RF_RD1 ^ w_op_b;
      3'b101:  w_alu = w_f7[5] ? 32'($signed(bus.RF_RD1) >>> w_shamt)
                               : (bus.RF_RD1 >> w_shamt);
      3'b110:  w_alu = bus.RF_RD1 | w_op_b;
      default: w_alu = bus.RF_RD1 & w_op_b;
    endcase
    if (w_opc == OPC_LUI) begin
      w_alu = {r_ir[31:12], 12'd0};
    end
  end

  // Store line: the read line with the addressed lane replaced by rs2.
  always_comb begin
    w_line = bus.D_MEM_DI;
    w_line[{r_ea[3:2], 5'b00000} +: 32] = r_rs2;
  end

  // Every enable is gated by reset so an in-flight load/store is dropped at once.
  assign w_active = ~RSTn;
  assign w_we_ex  = (r_state == S_EX)  && w_is_alu;
  assign w_we_mem = (r_state == S_MEM) && w_is_lw;

  assign bus.I_MEM_CSN  = ~(w_active && (r_state == S_IF));
  assign bus.I_MEM_ADDR = r_pc;
  assign bus.RF_RA1     = r_ir[19:15];
  assign bus.RF_RA2     = r_ir[24:20];
  assign bus.RF_WA1     = w_rd;
  assign bus.RF_WE      = w_active && (w_we_ex || w_we_mem) && (w_rd != 5'd0);
  assign bus.RF_WD      = w_we_ex ? w_alu : (w_we_mem ? w_lane : 32'd0);
  assign bus.D_MEM_CSN  = ~(w_active && (((r_state == S_EX) && w_is_mem) ||
                                         ((r_state == S_MEM) && w_is_sw)));
  assign bus.D_MEM_WEN  = ~(w_active && (r_state == S_MEM) && w_is_sw);
  assign bus.D_MEM_ADDR = ((r_state == S_EX) && w_is_mem) ? w_ea[13:4] : r_ea[13:4];
  assign bus.D_MEM_DOUT = ((r_state == S_MEM) && w_is_sw) ? w_line : 128'd0;

  assign HALT        = r_halt;
  assign NUM_INST    = r_num_inst;
  assign OUTPUT_PORT = r_out;
  assign o_dbg_state = r_state;

  // Instruction sequencer: fetch, decode, execute, optional line access, retire.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      r_state    <= S_IF;
      r_pc       <= 12'd0;
      r_ir       <= 32'd0;
      r_ea       <= '0;
      r_rs2      <= 32'd0;
      r_halt     <= 1'b0;
      r_num_inst <= 32'd0;
      r_out      <= 32'd0;
    end else begin
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          r_ir    <= bus.I_MEM_DI;
          r_state <= S_EX;
        end
        S_EX: begin
          if (w_is_ebreak) begin
            r_halt  <= 1'b1;
            r_state <= S_HALT;
          end else if (w_is_mem) begin
            r_ea    <= w_ea;
            r_rs2   <= bus.RF_RD2;
            r_state <= S_MEM;
          end else begin
            // ALU, LUI and unsupported encodings all retire here; only ALU/LUI report a result.
            r_pc       <= r_pc + 12'd4;
            r_num_inst <= r_num_inst + 32'd1;
            if (w_is_alu) begin
              r_out <= w_alu;
            end
            r_state <= S_IF;
          end
        end
        S_MEM: begin
          r_pc       <= r_pc + 12'd4;
          r_num_inst <= r_num_inst + 32'd1;
          r_out      <= w_is_lw ? w_lane : r_rs2;
          r_state    <= S_IF;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IF;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_top.sv
// Directed bench for riscv_top with SRAM and register-file models around the core.
module tb_riscv_top;
  logic        CLK;
  logic        RSTn;
  logic        HALT;
  logic [31:0] NUM_INST;
  logic [31:0] OUTPUT_PORT;
  logic [2:0]  dbg_state;

  riscv_top_if bus ();

  riscv_top dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .bus         (bus),
    .HALT        (HALT),
    .NUM_INST    (NUM_INST),
    .OUTPUT_PORT (OUTPUT_PORT),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- environment models ----------------
  logic [31:0]  imem [0:1023];
  logic [127:0] dmem [0:1023];
  logic [31:0]  rf   [0:31];
  logic [31:0]  imem_q;
  logic [127:0] dmem_q;
  logic         pl_en;
  logic [9:0]   pl_addr;
  logic [127:0] pl_data;
  int           n_fetch     = 0;
  int           n_dwrites   = 0;
  int           n_x0_writes = 0;

  assign bus.I_MEM_DI = imem_q;
  assign bus.D_MEM_DI = dmem_q;
  assign bus.RF_RD1   = (bus.RF_RA1 == 5'd0) ? 32'd0 : rf[bus.RF_RA1];
  assign bus.RF_RD2   = (bus.RF_RA2 == 5'd0) ? 32'd0 : rf[bus.RF_RA2];

  always @(posedge CLK) begin
    if (!bus.I_MEM_CSN) begin
      imem_q  <= imem[bus.I_MEM_ADDR[11:2]];
      n_fetch <= n_fetch + 1;
    end
  end

  always @(posedge CLK) begin
    if (pl_en) begin
      dmem[pl_addr] <= pl_data;
    end else if (!bus.D_MEM_CSN) begin
      if (!bus.D_MEM_WEN) begin
        dmem[bus.D_MEM_ADDR] <= bus.D_MEM_DOUT;
        n_dwrites <= n_dwrites + 1;
      end else begin
        dmem_q <= dmem[bus.D_MEM_ADDR];
      end
    end
  end

  always @(posedge CLK) begin
    if (bus.RF_WE) begin
      if (bus.RF_WA1 != 5'd0) rf[bus.RF_WA1] <= bus.RF_WD;
      else n_x0_writes <= n_x0_writes + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_num = 32'd0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Each retire (NUM_INST step) pops the expected OUTPUT_PORT value.
  always @(negedge CLK) begin
    if (NUM_INST != last_num) begin
      if (NUM_INST != 32'd0) begin
        if (exp_q.size() == 0) check_eq("retire_unexpected", NUM_INST, 128'd0);
        else check_eq("retire_out", OUTPUT_PORT, exp_q.pop_front());
      end
      last_num <= NUM_INST;
    end
  end

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [4:0] rd);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  localparam logic [31:0] EBREAK = 32'h00100073;

  // ---------------- driver tasks ----------------
  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
  endtask

  task automatic dmem_load(input logic [9:0] a, input logic [127:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge CLK);
    #1 pl_en = 1'b0;
  endtask

  // Hold reset for three edges, then check every output sits at its reset value.
  task automatic hold_reset();
    RSTn = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_i_csn",  bus.I_MEM_CSN, 1);
    check_eq("rst_i_addr", bus.I_MEM_ADDR, 0);
    check_eq("rst_d_csn",  bus.D_MEM_CSN, 1);
    check_eq("rst_d_wen",  bus.D_MEM_WEN, 1);
    check_eq("rst_d_addr", bus.D_MEM_ADDR, 0);
    check_eq("rst_d_dout", bus.D_MEM_DOUT, 0);
    check_eq("rst_rf_we",  bus.RF_WE, 0);
    check_eq("rst_rf_wd",  bus.RF_WD, 0);
    check_eq("rst_num",    NUM_INST, 0);
    check_eq("rst_out",    OUTPUT_PORT, 0);
    check_eq("rst_halt",   HALT, 0);
    check_eq("rst_state",  dbg_state, 0);
    exp_q.delete();
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 3000 && HALT !== 1'b1; i++) @(negedge CLK);
    check_eq(tag, HALT, 1);
  endtask

  int f0;
  int w0;
  int x0w;

  // ---------------- directed tests ----------------
  initial begin
    RSTn  = 1'b1;
    pl_en = 1'b0;
    pl_addr = 10'd0;
    pl_data = 128'd0;

    // Test 1: ADDI x1,x0,5 cycle by cycle, then EBREAK.
    clear_imem();
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
    imem[1] = EBREAK;
    hold_reset();
    exp_q.push_back(32'd5);
    RSTn = 1'b0;
    @(negedge CLK);
    check_eq("c1_i_csn",  bus.I_MEM_CSN, 0);
    check_eq("c1_i_addr", bus.I_MEM_ADDR, 0);
    @(negedge CLK);
    check_eq("c2_i_csn",  bus.I_MEM_CSN, 1);
    check_eq("c2_rf_we",  bus.RF_WE, 0);
    @(negedge CLK);
    check_eq("c3_rf_we",  bus.RF_WE, 1);
    check_eq("c3_rf_wa",  bus.RF_WA1, 1);
    check_eq("c3_rf_wd",  bus.RF_WD, 5);
    check_eq("c3_num",    NUM_INST, 0);
    @(posedge CLK);
    #1;
    check_eq("c3_num_after", NUM_INST, 1);
    check_eq("c3_out_after", OUTPUT_PORT, 5);
    check_eq("c4_rf_we",     bus.RF_WE, 0);
    wait_halt("t1_halt");
    check_eq("t1_num", NUM_INST, 1);
    f0 = n_fetch;
    repeat (10) @(negedge CLK);
    check_eq("t1_no_fetch", n_fetch, f0);
    check_eq("t1_halt_csn", bus.I_MEM_CSN, 1);
    check_eq("t1_x1", rf[1], 5);
    check_eq("t1_q_empty", exp_q.size(), 0);

    // Test 2: SW/LW with lane preservation and ignored EA[1:0].
    clear_imem();
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
    imem[1] = enc_sw(12'd4, 5'd1, 5'd0);
    imem[2] = enc_lw(12'd4, 5'd0, 5'd2);
    imem[3] = enc_i(12'hFF9, 5'd0, 3'b000, 5'd3);
    imem[4] = enc_sw(12'd28, 5'd3, 5'd0);
    imem[5] = enc_lw(12'd16, 5'd0, 5'd4);
    imem[6] = enc_lw(12'd31, 5'd0, 5'd5);
    imem[7] = EBREAK;
    hold_reset();
    dmem_load(10'd0, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000);
    dmem_load(10'd1, 128'h44440003_33330002_22220001_11110000);
    w0 = n_dwrites;
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'hFFFFFFF9);
    exp_q.push_back(32'hFFFFFFF9);
    exp_q.push_back(32'h11110000);
    exp_q.push_back(32'hFFFFFFF9);
    RSTn = 1'b0;
    wait_halt("t2_halt");
    check_eq("t2_num", NUM_INST, 7);
    check_eq("t2_line0", dmem[0], 128'hDDDD0003_CCCC0002_00000005_AAAA0000);
    check_eq("t2_line1", dmem[1], 128'hFFFFFFF9_33330002_22220001_11110000);
    check_eq("t2_dwrites", n_dwrites - w0, 2);
    check_eq("t2_x2", rf[2], 5);
    check_eq("t2_x4", rf[4], 32'h11110000);
    check_eq("t2_x5", rf[5], 32'hFFFFFFF9);
    check_eq("t2_q_empty", exp_q.size(), 0);

    // Test 3: shifts, compares, logic ops, LUI, unsupported NOP, write to x0.
    clear_imem();
    imem[0]  = enc_i(12'hFF0, 5'd0, 3'b000, 5'd1);
    imem[1]  = enc_i(12'h402, 5'd1, 3'b101, 5'd2);
    imem[2]  = enc_i(12'h002, 5'd1, 3'b101, 5'd3);
    imem[3]  = enc_i(12'h001, 5'd1, 3'b001, 5'd4);
    imem[4]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1);
    imem[5]  = enc_i(12'd1,   5'd0, 3'b000, 5'd2);
    imem[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);
    imem[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3);
    imem[8]  = enc_i(12'hFFF, 5'd2, 3'b011, 5'd3);
    imem[9]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3);
    imem[10] = enc_lui(20'h12345, 5'd5);
    imem[11] = enc_r(7'h00, 5'd5, 5'd2, 3'b110, 5'd6);
    imem[12] = enc_i(12'h0FF, 5'd5, 3'b100, 5'd7);
    imem[13] = enc_i(12'h0F0, 5'd1, 3'b111, 5'd8);
    imem[14] = enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd9);
    imem[15] = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd10);
    imem[16] = enc_r(7'h00, 5'd2, 5'd2, 3'b001, 5'd11);
    imem[17] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd12);
    imem[18] = enc_i(12'd0, 5'd1, 3'b010, 5'd13);
    imem[19] = enc_r(7'h00, 5'd6, 5'd5, 3'b111, 5'd14);
    imem[20] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd15);
    imem[21] = 32'h0000000B;
    imem[22] = enc_i(12'd7, 5'd0, 3'b000, 5'd0);
    imem[23] = EBREAK;
    hold_reset();
    w0  = n_dwrites;
    x0w = n_x0_writes;
    exp_q.push_back(32'hFFFFFFF0);
    exp_q.push_back(32'hFFFFFFFC);
    exp_q.push_back(32'h3FFFFFFC);
    exp_q.push_back(32'hFFFFFFE0);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h00000002);
    exp_q.push_back(32'h12345000);
    exp_q.push_back(32'h12345001);
    exp_q.push_back(32'h123450FF);
    exp_q.push_back(32'h000000F0);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h7FFFFFFF);
    exp_q.push_back(32'h00000002);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h12345000);
    exp_q.push_back(32'hFFFFFFFE);
    exp_q.push_back(32'hFFFFFFFE);
    exp_q.push_back(32'h00000007);
    RSTn = 1'b0;
    wait_halt("t3_halt");
    check_eq("t3_num", NUM_INST, 23);
    check_eq("t3_x2_srai", rf[2], 1);
    check_eq("t3_x4_slli", rf[4], 32'hFFFFFFE0);
    check_eq("t3_x3_sub", rf[3], 2);
    check_eq("t3_x9_sra", rf[9], 32'hFFFFFFFF);
    check_eq("t3_x0_writes", n_x0_writes - x0w, 0);
    check_eq("t3_dwrites", n_dwrites - w0, 0);
    check_eq("t3_q_empty", exp_q.size(), 0);

    // Test 4: reset during the MEM cycle of a store abandons the write.
    clear_imem();
    imem[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd1);
    imem[1] = enc_sw(12'd32, 5'd1, 5'd0);
    imem[2] = EBREAK;
    hold_reset();
    dmem_load(10'd2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    exp_q.push_back(32'd9);
    RSTn = 1'b0;
    for (int i = 0; i < 100 && dbg_state !== 3'd3; i++) @(negedge CLK);
    check_eq("t4_reach_mem", dbg_state, 3);
    check_eq("t4_mem_wen", bus.D_MEM_WEN, 0);
    w0 = n_dwrites;
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    check_eq("t4_dwrites", n_dwrites - w0, 0);
    check_eq("t4_line2", dmem[2], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    check_eq("t4_state", dbg_state, 0);
    check_eq("t4_num", NUM_INST, 0);
    check_eq("t4_out", OUTPUT_PORT, 0);
    check_eq("t4_d_csn", bus.D_MEM_CSN, 1);
    check_eq("t4_d_wen", bus.D_MEM_WEN, 1);
    check_eq("t4_d_dout", bus.D_MEM_DOUT, 0);
    check_eq("t4_rf_we", bus.RF_WE, 0);
    exp_q.delete();
    exp_q.push_back(32'd9);
    exp_q.push_back(32'd9);
    RSTn = 1'b0;
    @(negedge CLK);
    check_eq("t4_restart_csn", bus.I_MEM_CSN, 0);
    check_eq("t4_restart_pc", bus.I_MEM_ADDR, 0);
    wait_halt("t4_halt");
    check_eq("t4_num_end", NUM_INST, 2);
    check_eq("t4_line2_end", dmem[2], 128'h0123_4567_89AB_CDEF_FEDC_BA98_0000_0009);
    check_eq("t4_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case a wait above never resolves.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/riscv_top.md
# riscv_top

Multicycle RV32I-subset CPU core (`RISCV_TOP`) that sits between an external synchronous instruction SRAM, a 128-bit line-wide synchronous data memory and an external 32×32 register file (`REG_FILE`). The clock/reset source (`RISCV_CLKRST`) sits outside the core. The core fetches, executes and retires one instruction at a time. It exposes a retired-instruction counter, the last result (`OUTPUT_PORT`) and a `HALT` flag for self-checking benches.

## Interface
- No parameters; all widths fixed.
- `CLK` in 1: single clock, rising-edge.
- `RSTn` in 1: reset, synchronous, active-high (1 = reset).
- `I_MEM_CSN` out 1: instruction memory select, active-low.
- `I_MEM_ADDR` out 12: byte address, equal to PC[11:0]. Memory indexes words with [11:2].
- `I_MEM_DI` in 32: instruction word. Valid the cycle after the select edge.
- `D_MEM_CSN` out 1: data memory select, active-low.
- `D_MEM_WEN` out 1: 0 = write line, 1 = read.
- `D_MEM_ADDR` out 10: line index, equal to effective address [13:4].
- `D_MEM_DOUT` out 128: write line.
- `D_MEM_DI` in 128: read line. Valid the cycle after the read edge.
- `RF_RA1`, `RF_RA2` out 5: register file read addresses. Reads are combinational; x0 reads 0.
- `RF_RD1`, `RF_RD2` in 32: register file read data.
- `RF_WA1` out 5: register file write address.
- `RF_WD` out 32: register file write data.
- `RF_WE` out 1: register file write enable. The write happens at the rising edge when this is 1.
- `HALT` out 1: sticky halt flag.
- `NUM_INST` out 32: count of retired instructions.
- `OUTPUT_PORT` out 32: result of the most recently retired instruction.

## Operation
- **Supported instructions:**
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - LUI.
  - EBREAK (0x00100073).
- **Immediates:** I/S immediates are sign-extended 12-bit.
- **Shifts:** shift amount is the low 5 bits of the immediate or rs2. SRA/SRAI is arithmetic.
- **Compares:** SLT/SLTI are signed. SLTU/SLTIU are unsigned, and the immediate is still sign-extended first. All results are 32-bit, wrapping.
- **Loads and stores:** effective address = rs1 + imm.
  - Word select = EA[3:2], lane k = bits [32k+31:32k].
  - EA[1:0] is ignored; no misalignment trap.
- **rd = x0:** `RF_WE` is never asserted.
- **OUTPUT_PORT on retire:**
  - ALU ops and LUI: the result, including when rd = x0.
  - LW: the loaded word.
  - SW: the stored rs2 value.
- **Unsupported encodings:** retire as NOP. PC += 4, `NUM_INST` increments, `OUTPUT_PORT` is unchanged, no writes.
- **EBREAK:** sets `HALT`=1. It does not retire; `NUM_INST` is unchanged. The core then idles with all selects deasserted until reset.
- **State machine:**
  - **IF:** `I_MEM_CSN`=0, `I_MEM_ADDR`=PC.
  - **ID:** latch `I_MEM_DI` into IR.
  - **EX:** `RF_RA1`=IR[19:15], `RF_RA2`=IR[24:20], compute.
    - ALU/LUI: drive `RF_WE`/`RF_WA1`/`RF_WD`, retire, go to IF.
    - LW/SW: latch EA and rs2, issue line read (`D_MEM_CSN`=0, `WEN`=1), go to MEM.
  - **MEM:**
    - LW: write the selected lane of `D_MEM_DI` to rd and retire.
    - SW: drive `D_MEM_DOUT` = `D_MEM_DI` with the selected lane replaced by rs2, with `D_MEM_CSN`=0 and `WEN`=0. Retire.
    - Go to IF.
  - **HALTED:** terminal.
- **Retire (at the retiring edge):** PC += 4 (wraps at 4 KiB), `NUM_INST` += 1, `OUTPUT_PORT` updated. `NUM_INST` and `OUTPUT_PORT` change on the same edge.

## Timing
- **Reset** (`RSTn`=1 sampled at an edge): state=IF, PC=0, `NUM_INST`=0, `OUTPUT_PORT`=0, `HALT`=0, `I_MEM_CSN`=1, `D_MEM_CSN`=1, `D_MEM_WEN`=1, `RF_WE`=0. All addresses and data outputs are 0.
- **Reset mid-operation:** any pending load/store is abandoned with no memory or register write.
- First IF is the cycle after reset deasserts.
- **Cycles per instruction:** ALU/LUI/NOP = 3 (IF, ID, EX); LW = 4; SW = 4 (read-modify-write line).
- Memory select outputs are asserted only in the states listed; otherwise `CSN`=1 and `WEN`=1.
- `RF_WE` is high for exactly one cycle per writing instruction.
- Results of instruction k are visible to instruction k+1's EX through the register file; no bypass is needed.

## Test plan
- Reset, then ADDI x1,x0,5 → `RF_WE` pulse with `WA1`=1 and `WD`=5 in cycle 3. `NUM_INST`=1 and `OUTPUT_PORT`=5 after that edge.
- x1=5, then SW x1,4(x0) → line 0 read, then written with lane 1 = 5 and lanes 0/2/3 preserved. Then LW x2,4(x0) → `OUTPUT_PORT`=5, `RF_WA1`=2.
- x1=0xFFFFFFF0 → SRAI 2 = 0xFFFFFFFC, SRLI 2 = 0x3FFFFFFC, SLLI 1 = 0xFFFFFFE0.
- x1=−1, x2=1 → SLT x3,x1,x2 = 1; SLTU x3,x1,x2 = 0; SLTIU x3,x2,−1 = 1; SUB x3,x2,x1 = 2.
- ADDI x0,x0,7 → `RF_WE` stays 0, `OUTPUT_PORT`=7. EBREAK next → `HALT`=1, `NUM_INST` unchanged, no further fetches.
- Assert `RSTn` during the MEM state of a SW → no D-memory write occurs. All outputs take reset values on the next edge and execution restarts at PC=0.
